// File: rtl/serial_word_if.sv
// serial_word_if: serial bit input and valid/ready word output of the deserializer
interface serial_word_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH);

    logic             d_in;
    logic             d_en;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;
    logic [CW-1:0]    bit_count;
    logic             overflow;

    modport master (
        input  d_in, d_en, word_ready,
        output word_out, word_valid, bit_count, overflow
    );

    modport slave (
        output d_in, d_en, word_ready,
        input  word_out, word_valid, bit_count, overflow
    );
endinterface

// File: rtl/serial_word_deserializer.sv
// serial_word_deserializer: packs serial bits into words behind a one-word valid/ready buffer
module serial_word_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    serial_word_if.master       bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] shifted;
    logic             done;

    // Next state: shift/count, then buffer load, drop-with-overflow, or drain
    always_comb begin
        shifted = MSB_FIRST ? {shift_q[WIDTH-2:0], bus.d_in} : {bus.d_in, shift_q[WIDTH-1:1]};
        done    = bus.d_en && (count_q == CW'(WIDTH - 1));
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        word_d  = word_q;
        ovf_d   = ovf_q;
        if (clr) begin
            state_d = EMPTY;
            shift_d = '0;
            count_d = '0;
            word_d  = '0;
            ovf_d   = 1'b0;
        end else begin
            if (bus.d_en) begin
                shift_d = shifted;
                count_d = done ? '0 : count_q + CW'(1);
            end
            if (done && (state_q == EMPTY || bus.word_ready)) begin
                word_d  = shifted;
                state_d = FULL;
            end else if (done) begin
                ovf_d = 1'b1;
            end else if (state_q == FULL && bus.word_ready) begin
                state_d = EMPTY;
            end
        end
    end

    // Register all state; async reset discards any partial or buffered word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            shift_q <= '0;
            count_q <= '0;
            word_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
            word_q  <= word_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.word_out   = word_q;
    assign bus.word_valid = (state_q == FULL);
    assign bus.bit_count  = count_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_serial_word_deserializer.sv
// tb_serial_word_deserializer: table vectors plus multi-cycle corner sequences for both bit orders
module tb_serial_word_deserializer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    logic [7:0] sbq[$];

    serial_word_if #(.WIDTH(8)) i1 ();
    serial_word_if #(.WIDTH(8)) i0 ();

    serial_word_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(i1)
    );
    serial_word_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(i0)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         m;
        logic [7:0] tx;
        int         gap;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit s, input logic b, input logic en);
        if (s) begin
            i1.d_in = b;
            i1.d_en = en;
        end else begin
            i0.d_in = b;
            i0.d_en = en;
        end
    endtask

    task automatic set_ready(input bit s, input logic r);
        if (s) i1.word_ready = r;
        else   i0.word_ready = r;
    endtask

    function automatic logic [7:0] w(input bit s);
        return s ? i1.word_out : i0.word_out;
    endfunction
    function automatic logic v(input bit s);
        return s ? i1.word_valid : i0.word_valid;
    endfunction
    function automatic logic [2:0] c(input bit s);
        return s ? i1.bit_count : i0.bit_count;
    endfunction
    function automatic logic o(input bit s);
        return s ? i1.overflow : i0.overflow;
    endfunction

    // Sends n bits of tx, tx[7] first, on consecutive edges
    task automatic send_bits(input bit s, input logic [7:0] tx, input int n);
        for (int k = 0; k < n; k++) begin
            drive(s, tx[7-k], 1'b1);
            tick();
        end
        drive(s, 1'b0, 1'b0);
    endtask

    task automatic chk_zero(input string name);
        for (int s = 0; s < 2; s++) begin
            chk({name, "_word"}, w(s[0]), 0);
            chk({name, "_valid"}, v(s[0]), 0);
            chk({name, "_count"}, c(s[0]), 0);
            chk({name, "_ovf"}, o(s[0]), 0);
        end
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'hA5, 0, 8'hA5};
        tbl[1] = '{1'b0, 8'hA5, 0, 8'hA5};
        tbl[2] = '{1'b0, 8'h80, 0, 8'h01};
        tbl[3] = '{1'b1, 8'hA5, 3, 8'hA5};
        tbl[4] = '{1'b0, 8'hE0, 2, 8'h07};
        tbl[5] = '{1'b1, 8'h3C, 0, 8'h3C};
        tbl[6] = '{1'b1, 8'hFF, 1, 8'hFF};
        tbl[7] = '{1'b0, 8'hC0, 0, 8'h03};
        i1.d_in = 1'b0; i1.d_en = 1'b0; i1.word_ready = 1'b1;
        i0.d_in = 1'b0; i0.d_en = 1'b0; i0.word_ready = 1'b1;
        #2;
        chk_zero("reset");
        rst_n = 1'b1;
        tick();
        chk_zero("post_reset");
        // Table vectors, ready held high
        foreach (tbl[i]) begin
            sbq.push_back(tbl[i].exp);
            for (int k = 0; k < 8; k++) begin
                drive(tbl[i].m, tbl[i].tx[7-k], 1'b1);
                tick();
                drive(tbl[i].m, 1'b0, 1'b0);
                if (k < 7) begin
                    chk("bit_count", c(tbl[i].m), k + 1);
                    chk("valid_early", v(tbl[i].m), 0);
                    for (int g = 0; g < tbl[i].gap; g++) begin
                        tick();
                        chk("gap_hold", c(tbl[i].m), k + 1);
                    end
                end
            end
            chk("done_valid", v(tbl[i].m), 1);
            chk("done_word", w(tbl[i].m), sbq.pop_front());
            chk("done_count", c(tbl[i].m), 0);
            tick();
            chk("accept_valid", v(tbl[i].m), 0);
            chk("accept_word_keep", w(tbl[i].m), tbl[i].exp);
        end
        // Backpressure: second word dropped, overflow sticky
        set_ready(1'b1, 1'b0);
        sbq.push_back(8'h3C);
        send_bits(1'b1, 8'h3C, 8);
        chk("bp_valid1", v(1'b1), 1);
        chk("bp_word1", w(1'b1), sbq.pop_front());
        send_bits(1'b1, 8'hC3, 8);
        chk("bp_word2", w(1'b1), 8'h3C);
        chk("bp_ovf", o(1'b1), 1);
        chk("bp_valid2", v(1'b1), 1);
        set_ready(1'b1, 1'b1);
        tick();
        chk("bp_drain_valid", v(1'b1), 0);
        chk("bp_ovf_sticky", o(1'b1), 1);
        sbq.push_back(8'h5A);
        send_bits(1'b1, 8'h5A, 8);
        chk("bp_after_word", w(1'b1), sbq.pop_front());
        chk("bp_after_ovf", o(1'b1), 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_ovf", o(1'b1), 0);
        // Back-to-back: ready only on the second completion edge
        set_ready(1'b1, 1'b0);
        sbq.push_back(8'hF0);
        send_bits(1'b1, 8'hF0, 8);
        chk("b2b_word1", w(1'b1), sbq.pop_front());
        send_bits(1'b1, 8'h0F, 7);
        chk("b2b_hold", w(1'b1), 8'hF0);
        chk("b2b_hold_valid", v(1'b1), 1);
        set_ready(1'b1, 1'b1);
        sbq.push_back(8'h0F);
        drive(1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b1, 1'b0, 1'b0);
        chk("b2b_valid", v(1'b1), 1);
        chk("b2b_word2", w(1'b1), sbq.pop_front());
        chk("b2b_ovf", o(1'b1), 0);
        tick();
        chk("b2b_drain", v(1'b1), 0);
        // Async reset mid-word with a buffered word, then a clean word
        set_ready(1'b1, 1'b0);
        send_bits(1'b1, 8'h3C, 8);
        send_bits(1'b1, 8'hFF, 5);
        chk("pre_rst_count", c(1'b1), 5);
        rst_n = 1'b0;
        #2;
        chk_zero("async_rst");
        rst_n = 1'b1;
        set_ready(1'b1, 1'b1);
        sbq.push_back(8'h81);
        send_bits(1'b1, 8'h81, 8);
        chk("rst_word", w(1'b1), sbq.pop_front());
        chk("rst_valid", v(1'b1), 1);
        tick();
        // Same with synchronous clear, on both instances
        set_ready(1'b1, 1'b0);
        send_bits(1'b1, 8'h3C, 8);
        send_bits(1'b1, 8'hFF, 5);
        send_bits(1'b0, 8'hFF, 5);
        clr = 1'b1;
        drive(1'b1, 1'b1, 1'b1);
        tick();
        clr = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        chk_zero("clr");
        set_ready(1'b1, 1'b1);
        sbq.push_back(8'h81);
        send_bits(1'b1, 8'h81, 8);
        chk("clr_word", w(1'b1), sbq.pop_front());
        sbq.push_back(8'h81);
        send_bits(1'b0, 8'h81, 8);
        chk("clr_word_lsb", w(1'b0), sbq.pop_front());
        chk("sb_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
